// File: rtl/riscv_pkg.sv
// Shared constants and payload types for the data-memory responder and its store buffer.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned MEM_WORDS  = 1024;
    localparam int unsigned WORD_IDX_W = $clog2(MEM_WORDS);
    localparam int unsigned BE_W       = XLEN / 8;

    localparam logic [2:0] SIZE_B = 3'b001;
    localparam logic [2:0] SIZE_H = 3'b010;
    localparam logic [2:0] SIZE_W = 3'b100;

    typedef logic [WORD_IDX_W-1:0] word_idx_t;

    typedef struct packed {
        word_idx_t         word_idx;
        logic [BE_W-1:0]   be;
        logic [XLEN-1:0]   data;
    } sb_entry_t;

    // Unshifted byte mask for a one-hot access size; an illegal size yields no bytes.
    function automatic logic [BE_W-1:0] size_mask(input logic [2:0] size);
        case (size)
            SIZE_B:  return 4'b0001;
            SIZE_H:  return 4'b0011;
            SIZE_W:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_sb.sv
// In-order store buffer: FIFO of byte-masked word writes with youngest-match
// per-byte forwarding for loads.
module dmem_sb
    import riscv_pkg::*;
#(
    parameter int unsigned SB_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  sb_entry_t                  push_entry,
    input  logic                       pop,
    output sb_entry_t                  head_entry,
    output logic [$clog2(SB_DEPTH):0]  count,
    output logic                       empty,
    output logic                       full,
    input  word_idx_t                  lookup_idx,
    output logic [BE_W-1:0]            fwd_hit,
    output logic [XLEN-1:0]            fwd_data
);

    localparam int unsigned PTR_W = $clog2(SB_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    sb_entry_t        entries [SB_DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt;
    logic             empty_q;
    logic             full_q;
    logic             pop_ok;
    logic             push_ok;

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign pop_ok  = pop & ~empty_q;
    assign push_ok = push & (~full_q | pop_ok);

    always_comb begin
        count_nxt = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count_q + CNT_W'(1);
            2'b01:   count_nxt = count_q - CNT_W'(1);
            default: count_nxt = count_q;
        endcase
    end

    // Pointers wrap naturally because SB_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            if (push_ok) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (pop_ok) begin
                head_q <= head_q + PTR_W'(1);
            end
            count_q <= count_nxt;
            empty_q <= (count_nxt == '0);
            full_q  <= (count_nxt == CNT_W'(SB_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            entries[tail_q] <= push_entry;
        end
    end

    // Walk oldest to youngest so later matches overwrite earlier ones byte by byte.
    always_comb begin
        fwd_hit  = '0;
        fwd_data = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            logic [PTR_W-1:0] idx;
            idx = head_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (entries[idx].word_idx == lookup_idx)) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (entries[idx].be[b]) begin
                        fwd_hit[b]          = 1'b1;
                        fwd_data[8*b +: 8]  = entries[idx].data[8*b +: 8];
                    end
                end
            end
        end
    end

    assign head_entry = entries[head_q];
    assign count      = count_q;
    assign empty      = empty_q;
    assign full       = full_q;

    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        count_q <= CNT_W'(SB_DEPTH));

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && full_q && !pop));

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: byte-enabled array with asynchronous read, fronted by
// a store buffer that drains when the port is not needed for a load.
module dmem_resp
    import riscv_pkg::*;
#(
    parameter int unsigned SB_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       adr_v_i,
    input  logic [XLEN-1:0]            adr_i,
    input  logic                       is_store_i,
    input  logic [XLEN-1:0]            store_data_i,
    input  logic [2:0]                 access_size_i,
    output logic [XLEN-1:0]            load_data_o,
    output logic                       sb_empty_o,
    output logic [$clog2(SB_DEPTH):0]  sb_count_o,
    output logic                       misaligned_q_o
);

    logic [XLEN-1:0]   mem [MEM_WORDS];

    word_idx_t         word_idx;
    logic [1:0]        byte_off;
    logic [2*BE_W-1:0] be_wide;
    logic [BE_W-1:0]   be;
    logic              misaligned;
    logic [XLEN-1:0]   data_sh;
    logic              is_st;
    logic              drain;
    logic              push;
    logic              sb_empty;
    logic              sb_full;
    sb_entry_t         push_entry;
    sb_entry_t         head_entry;
    logic [BE_W-1:0]   fwd_hit;
    logic [XLEN-1:0]   fwd_data;
    logic [XLEN-1:0]   rd_word;
    logic              misaligned_q;
    logic              unused_adr_hi;

    // Address bits above the array depth alias onto the same words.
    assign unused_adr_hi = ^adr_i[XLEN-1:WORD_IDX_W+2];

    assign word_idx   = adr_i[WORD_IDX_W+1:2];
    assign byte_off   = adr_i[1:0];
    assign be_wide    = {4'b0000, size_mask(access_size_i)} << byte_off;
    assign be         = be_wide[BE_W-1:0];
    assign misaligned = |be_wide[2*BE_W-1:BE_W];
    assign data_sh    = store_data_i << {byte_off, 3'b000};

    assign is_st = adr_v_i & is_store_i;
    assign push  = is_st & (|be);

    // Idle cycles drain; a store cycle drains only to make room in a full buffer.
    assign drain = ~sb_empty & (~adr_v_i | (is_st & sb_full));

    always_comb begin
        push_entry          = '0;
        push_entry.word_idx = word_idx;
        push_entry.be       = be;
        push_entry.data     = data_sh;
    end

    dmem_sb #(
        .SB_DEPTH (SB_DEPTH)
    ) u_sb (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (drain),
        .head_entry (head_entry),
        .count      (sb_count_o),
        .empty      (sb_empty),
        .full       (sb_full),
        .lookup_idx (word_idx),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data)
    );

    // Drains are suppressed during reset so pending stores are discarded, not committed.
    always_ff @(posedge clk) begin
        if (drain && !reset) begin
            for (int b = 0; b < BE_W; b++) begin
                if (head_entry.be[b]) begin
                    mem[head_entry.word_idx][8*b +: 8] <= head_entry.data[8*b +: 8];
                end
            end
        end
    end

    assign rd_word = mem[word_idx];

    always_comb begin
        load_data_o = rd_word;
        for (int b = 0; b < BE_W; b++) begin
            if (fwd_hit[b]) begin
                load_data_o[8*b +: 8] = fwd_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= adr_v_i & misaligned;
        end
    end

    assign misaligned_q_o = misaligned_q;
    assign sb_empty_o     = sb_empty;

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: directed vector table, hand sequences and a randomized run
// against an architectural memory model.
module tb_dmem_resp;
    import riscv_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int unsigned WIN   = 32;

    logic          clk;
    logic          reset;
    logic          adr_v;
    logic          is_store;
    logic [31:0]   adr;
    logic [31:0]   store_data;
    logic [2:0]    access_size;
    logic [31:0]   load_data;
    logic          sb_empty;
    logic [CW-1:0] sb_count;
    logic          misaligned_q;

    dmem_resp #(.SB_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .adr_v_i        (adr_v),
        .adr_i          (adr),
        .is_store_i     (is_store),
        .store_data_i   (store_data),
        .access_size_i  (access_size),
        .load_data_o    (load_data),
        .sb_empty_o     (sb_empty),
        .sb_count_o     (sb_count),
        .misaligned_q_o (misaligned_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_bad = 0;

    // arch: every accepted store applied immediately; phys: only stores that reached the array.
    logic [31:0] arch [1024];
    logic [31:0] phys [1024];
    typedef struct {
        int         widx;
        logic [3:0] be;
        logic [31:0] data;
    } pend_t;
    pend_t pq[$];
    logic  m_mis;

    typedef struct {
        logic        v;
        logic        st;
        logic [31:0] adr;
        logic [31:0] data;
        logic [2:0]  size;
        bit          chk;
        logic [31:0] exp_ld;
        int          exp_cnt;
        logic        exp_mis;
    } vec_t;
    vec_t tbl[$];

    logic [31:0]   ld;
    logic [CW-1:0] cnt;
    logic          mis;

    function automatic logic [31:0] init_word(input int i);
        return {8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3)};
    endfunction

    function automatic logic [31:0] a_val(input int k);
        return 32'hA0A0_0000 + 32'(k);
    endfunction

    function automatic logic [31:0] b_val(input int k);
        return 32'hB0B0_0000 + 32'(k);
    endfunction

    function automatic void add(input logic v, input logic st, input logic [31:0] a,
                                input logic [31:0] d, input logic [2:0] sz, input bit chk,
                                input logic [31:0] eld, input int ecnt, input logic emis);
        vec_t r;
        r.v = v; r.st = st; r.adr = a; r.data = d; r.size = sz;
        r.chk = chk; r.exp_ld = eld; r.exp_cnt = ecnt; r.exp_mis = emis;
        tbl.push_back(r);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Architectural rules applied at the clock edge, using the inputs of the cycle just sampled.
    task automatic model_step(input logic v, input logic st, input logic [31:0] a,
                              input logic [31:0] d, input logic [2:0] sz);
        int         nb;
        int         off;
        int         widx;
        logic [3:0] be;
        logic [31:0] wd;
        bit         pop;
        pend_t      e;
        nb   = (sz == SIZE_B) ? 1 : (sz == SIZE_H) ? 2 : (sz == SIZE_W) ? 4 : 0;
        off  = int'(a[1:0]);
        widx = int'(a[11:2]);
        pop  = (pq.size() > 0) && (!v || (st && pq.size() == DEPTH));
        if (pop) begin
            e = pq.pop_front();
            for (int b = 0; b < 4; b++)
                if (e.be[b]) phys[e.widx][8*b +: 8] = e.data[8*b +: 8];
        end
        if (v && st) begin
            be = '0;
            wd = '0;
            for (int b = off; b < 4 && b < off + nb; b++) begin
                be[b]          = 1'b1;
                wd[8*b +: 8]   = d[8*(b - off) +: 8];
            end
            if (be != 4'b0000) begin
                e.widx = widx; e.be = be; e.data = wd;
                pq.push_back(e);
                for (int b = 0; b < 4; b++)
                    if (be[b]) arch[widx][8*b +: 8] = wd[8*b +: 8];
            end
        end
        m_mis = v && (nb > 0) && (off + nb > 4);
    endtask

    task automatic cyc(input logic a_v, input logic a_st, input logic [31:0] a_adr,
                       input logic [31:0] a_data, input logic [2:0] a_size, input bit chk_ld,
                       output logic [31:0] o_ld, output logic [CW-1:0] o_cnt, output logic o_mis);
        adr_v       = a_v;
        is_store    = a_st;
        adr         = a_adr;
        store_data  = a_data;
        access_size = a_size;
        #4;
        o_ld  = load_data;
        o_cnt = sb_count;
        o_mis = misaligned_q;
        if (chk_ld) check("load_data", o_ld, arch[a_adr[11:2]]);
        check("sb_count", 32'(o_cnt), 32'(pq.size()));
        check("sb_empty", 32'(sb_empty), 32'(pq.size() == 0));
        check("misaligned_q", 32'(o_mis), 32'(m_mis));
        model_step(a_v, a_st, a_adr, a_data, a_size);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        adr_v = 1'b0;
        is_store = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 1024; i++) arch[i] = phys[i];
        pq.delete();
        m_mis = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        adr_v = 1'b0;
        is_store = 1'b0;
        adr = '0;
        store_data = '0;
        access_size = SIZE_W;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        pq.delete();
        m_mis = 1'b0;

        // Reset state
        cyc(0, 0, 32'h0, 32'h0, SIZE_W, 0, ld, cnt, mis);
        check("reset_count", 32'(cnt), 32'd0);
        check("reset_mis", 32'(mis), 32'd0);

        // Give every word of the test window a known value
        for (int i = 0; i < WIN; i++) begin
            cyc(1, 1, 32'(4 * i), init_word(i), SIZE_W, 0, ld, cnt, mis);
            cyc(0, 0, 32'(4 * i), 32'h0, SIZE_W, 1, ld, cnt, mis);
        end

        // Directed vectors
        add(1, 1, 32'h10, 32'hDEADBEEF, SIZE_W, 0, 32'h0, 0, 0);
        add(1, 0, 32'h10, 32'h0, SIZE_W, 1, 32'hDEADBEEF, 1, 0);
        add(0, 0, 32'h10, 32'h0, SIZE_W, 1, 32'hDEADBEEF, 1, 0);
        add(1, 1, 32'h20, 32'h11223344, SIZE_W, 0, 32'h0, 0, 0);
        add(1, 1, 32'h21, 32'h000000AA, SIZE_B, 0, 32'h0, 1, 0);
        add(1, 0, 32'h20, 32'h0, SIZE_W, 1, 32'h1122AA44, 2, 0);
        add(0, 0, 32'h20, 32'h0, SIZE_W, 1, 32'h1122AA44, 2, 0);
        add(0, 0, 32'h20, 32'h0, SIZE_W, 1, 32'h1122AA44, 1, 0);
        add(1, 0, 32'h20, 32'h0, SIZE_W, 1, 32'h1122AA44, 0, 0);
        for (int k = 0; k < 4; k++) begin
            add(1, 1, 32'h40 + 32'(4 * k), a_val(k), SIZE_W, 0, 32'h0, k, 0);
            add(1, 0, 32'h40 + 32'(4 * k), 32'h0, SIZE_W, 1, a_val(k), k + 1, 0);
        end
        add(1, 1, 32'h50, a_val(4), SIZE_W, 0, 32'h0, 4, 0);
        add(1, 0, 32'h50, 32'h0, SIZE_W, 1, a_val(4), 4, 0);
        for (int k = 0; k < 4; k++)
            add(1, 0, 32'h40 + 32'(4 * k), 32'h0, SIZE_W, 1, a_val(k), 4, 0);
        for (int k = 0; k < 8; k++)
            add(1, 1, 32'h60 + 32'(4 * k), b_val(k), SIZE_W, 0, 32'h0, 4, 0);
        for (int k = 0; k < 4; k++)
            add(0, 0, 32'h60, 32'h0, SIZE_W, 1, b_val(0), 4 - k, 0);
        for (int k = 0; k < 8; k++)
            add(1, 0, 32'h60 + 32'(4 * k), 32'h0, SIZE_W, 1, b_val(k), 0, 0);
        add(1, 0, 32'h44, 32'h0, SIZE_W, 1, a_val(1), 0, 0);
        add(1, 1, 32'h03, 32'hCAFEBABE, SIZE_W, 0, 32'h0, 0, 0);
        add(0, 0, 32'h00, 32'h0, SIZE_W, 1, 32'hBE010203, 1, 1);
        add(0, 0, 32'h00, 32'h0, SIZE_W, 1, 32'hBE010203, 0, 0);
        add(1, 0, 32'h00, 32'h0, SIZE_W, 1, 32'hBE010203, 0, 0);
        add(1, 0, 32'h07, 32'h0, SIZE_H, 1, init_word(1), 0, 0);
        add(1, 0, 32'h07, 32'h0, SIZE_B, 1, init_word(1), 0, 1);
        add(0, 0, 32'h04, 32'h0, SIZE_W, 1, init_word(1), 0, 0);

        foreach (tbl[i]) begin
            cyc(tbl[i].v, tbl[i].st, tbl[i].adr, tbl[i].data, tbl[i].size, tbl[i].chk, ld, cnt, mis);
            if (tbl[i].chk) check($sformatf("vec%0d_load", i), ld, tbl[i].exp_ld);
            check($sformatf("vec%0d_count", i), 32'(cnt), 32'(tbl[i].exp_cnt));
            check($sformatf("vec%0d_mis", i), 32'(mis), 32'(tbl[i].exp_mis));
        end

        // Pending stores discarded by reset
        cyc(1, 1, 32'h08, 32'h55555555, SIZE_W, 0, ld, cnt, mis);
        cyc(1, 1, 32'h0F, 32'h00007777, SIZE_H, 0, ld, cnt, mis);
        cyc(1, 0, 32'h08, 32'h0, SIZE_W, 1, ld, cnt, mis);
        check("prereset_load", ld, 32'h55555555);
        check("prereset_count", 32'(cnt), 32'd2);
        check("prereset_mis", 32'(mis), 32'd1);
        do_reset();
        cyc(1, 0, 32'h08, 32'h0, SIZE_W, 1, ld, cnt, mis);
        check("postreset_load0", ld, init_word(2));
        check("postreset_count", 32'(cnt), 32'd0);
        check("postreset_mis", 32'(mis), 32'd0);
        cyc(1, 0, 32'h0C, 32'h0, SIZE_W, 1, ld, cnt, mis);
        check("postreset_load1", ld, init_word(3));

        // Randomized traffic with aliased upper address bits
        for (int i = 0; i < 700; i++) begin
            logic        rv;
            logic        rst_s;
            logic [31:0] ra;
            logic [2:0]  rs;
            int          r;
            rv    = ((i / 50) % 2 == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            rst_s = 1'($urandom_range(0, 1));
            ra    = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, WIN - 1)) << 2)
                    | 32'($urandom_range(0, 3));
            r     = $urandom_range(0, 9);
            rs    = (r < 3) ? SIZE_B : (r < 6) ? SIZE_H : (r < 9) ? SIZE_W
                    : (($urandom_range(0, 1) == 1) ? 3'b011 : 3'b000);
            cyc(rv, rst_s, ra, $urandom, rs, 1, ld, cnt, mis);
        end

        // Drain and sweep the window from the array
        for (int i = 0; i < DEPTH + 1; i++)
            cyc(0, 0, 32'h0, 32'h0, SIZE_W, 1, ld, cnt, mis);
        check("final_empty", 32'(sb_empty), 32'd1);
        for (int i = 0; i < WIN; i++)
            cyc(1, 0, 32'(4 * i), 32'h0, SIZE_W, 1, ld, cnt, mis);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
